// File: rtl/sr_ff_checker.sv
// sr_ff_checker -- built-in self-test sequencer for an external master-slave
// SR flip-flop that shares clock C with this block.
//
// A run steps through a fixed 12-entry table of S/R drive patterns.
// Each vector is held for two edges (DRIVE, then SAMPLE). On the edge that
// leaves SAMPLE, the flip-flop's Q/nQ outputs are compared against a
// behavioural SR model. The model is not checked while its state is unknown,
// which is from start until the first S!=R step, and again after S=R=1.
//
// Ports:
//   C          clock, rising edge
//   nRST       asynchronous active-low reset
//   start      level; begins a run when sampled in IDLE or DONE
//   q_in/nq_in Q and nQ from the flip-flop under test (same clock domain)
//   s_out/r_out registered S/R drive to the flip-flop under test
//   busy       run in progress
//   done       run complete; held until restart or reset
//   pass       done with zero mismatches
//   err_cnt    mismatch count, saturates at 15
//   fail_step  first failing step index, 4'hF when none
//   step       current vector index
module sr_ff_checker (
    input  logic       C,
    input  logic       nRST,
    input  logic       start,
    input  logic       q_in,
    input  logic       nq_in,
    output logic       s_out,
    output logic       r_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [3:0] fail_step,
    output logic [3:0] step
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t     state, state_n;
    logic       valid, valid_n;
    logic       s_n, r_n, busy_n, done_n;
    logic [3:0] err_n, fail_n, step_n;
    logic [2:0] cur_v, nxt_v;
    logic       valid_now, mismatch;

    // Table entry {S, R, expected Q}. The expected Q of the S=R=1 entry is
    // unused because the model is invalid there.
    function automatic logic [2:0] vec(input logic [3:0] i);
        case (i)
            4'd0:    vec = 3'b010;
            4'd1:    vec = 3'b000;
            4'd2:    vec = 3'b101;
            4'd3:    vec = 3'b001;
            4'd4:    vec = 3'b010;
            4'd5:    vec = 3'b101;
            4'd6:    vec = 3'b110;
            4'd7:    vec = 3'b000;
            4'd8:    vec = 3'b101;
            4'd9:    vec = 3'b001;
            4'd10:   vec = 3'b010;
            4'd11:   vec = 3'b000;
            default: vec = 3'b000;
        endcase
    endfunction

    assign cur_v = vec(step);
    assign nxt_v = vec(step + 4'd1);

    // Model validity with the current vector applied: S!=R makes Q known,
    // S=R=1 makes it unknown, and S=R=0 keeps the previous knowledge.
    always_comb begin
        valid_now = valid;
        if (cur_v[2] != cur_v[1])
            valid_now = 1'b1;
        else if (cur_v[2] && cur_v[1])
            valid_now = 1'b0;
    end

    assign mismatch = valid_now && ((q_in != cur_v[0]) || (nq_in != ~cur_v[0]));
    assign pass     = done && (err_cnt == 4'd0);

    always_comb begin
        state_n = state;
        valid_n = valid;
        s_n     = s_out;
        r_n     = r_out;
        busy_n  = busy;
        done_n  = done;
        err_n   = err_cnt;
        fail_n  = fail_step;
        step_n  = step;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = DRIVE;
                    valid_n = 1'b0;
                    err_n   = 4'd0;
                    fail_n  = 4'hF;
                    step_n  = 4'd0;
                    s_n     = vec(4'd0) >> 2;
                    r_n     = vec(4'd0) >> 1 & 3'b001;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                end
            end
            DRIVE: state_n = SAMPLE;
            SAMPLE: begin
                valid_n = valid_now;
                if (mismatch) begin
                    if (err_cnt != 4'hF)
                        err_n = err_cnt + 4'd1;
                    if (fail_step == 4'hF)
                        fail_n = step;
                end
                if (step == 4'd11) begin
                    state_n = DONE;
                    s_n     = 1'b0;
                    r_n     = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n = DRIVE;
                    step_n  = step + 4'd1;
                    s_n     = nxt_v[2];
                    r_n     = nxt_v[1];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge C or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= 1'b0;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= 4'd0;
            fail_step <= 4'hF;
            step      <= 4'd0;
        end else begin
            state     <= state_n;
            valid     <= valid_n;
            s_out     <= s_n;
            r_out     <= r_n;
            busy      <= busy_n;
            done      <= done_n;
            err_cnt   <= err_n;
            fail_step <= fail_n;
            step      <= step_n;
        end
    end

endmodule

// File: tb/tb_sr_ff_checker.sv
// tb_sr_ff_checker -- drives runs of sr_ff_checker against a behavioural
// master-slave SR flip-flop with injectable faults. Each run pushes its
// predicted result into a queue; a monitor pops and compares when done rises.
module tb_sr_ff_checker;

    logic       C, nRST, start, q_in, nq_in;
    logic       s_out, r_out, busy, done, pass;
    logic [3:0] err_cnt, fail_step, step;

    sr_ff_checker dut (
        .C(C), .nRST(nRST), .start(start), .q_in(q_in), .nq_in(nq_in),
        .s_out(s_out), .r_out(r_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_step(fail_step), .step(step)
    );

    typedef struct {
        int         c0;
        logic [3:0] err;
        logic [3:0] fs;
        logic       ps;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cur_c0 = -1000;
    int   mode  = 0;          // 0 healthy, 1 Q stuck 0, 2 Q stuck 1, 3 nQ=Q
    logic [11:0] mask = '0;   // per-step Q/nQ inversion at the compare point
    logic flip = 1'b0;

    bit s_t[12] = '{0,0,1,0,0,1,1,0,1,0,0,0};
    bit r_t[12] = '{1,0,0,0,1,0,1,0,0,0,1,0};

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    always @(posedge C) cyc <= cyc + 1;

    // Flip-flop under test: master follows S/R on the rising edge,
    // slave copies master on the falling edge.
    logic m_q = 1'b0, ff_q = 1'b0;
    always @(posedge C) begin
        if (s_out && !r_out)      m_q <= 1'b1;
        else if (r_out && !s_out) m_q <= 1'b0;
        else if (s_out && r_out)  m_q <= 1'($urandom_range(0, 1));
    end
    always @(negedge C) ff_q <= m_q;

    always_comb begin
        case (mode)
            1:       begin q_in = 1'b0 ^ flip; nq_in = 1'b1 ^ flip; end
            2:       begin q_in = 1'b1 ^ flip; nq_in = 1'b0 ^ flip; end
            3:       begin q_in = ff_q ^ flip; nq_in = ff_q ^ flip; end
            default: begin q_in = ff_q ^ flip; nq_in = ~ff_q ^ flip; end
        endcase
    end

    // Step k is compared on the edge 2k+2 after the start edge, so the
    // inversion for step k is asserted across the preceding cycle.
    initial begin
        forever begin
            @(posedge C);
            #1;
            begin
                int rel;
                rel = cyc - cur_c0;
                if (rel >= 1 && rel <= 23 && (rel % 2) == 1)
                    flip = mask[(rel - 1) / 2];
                else
                    flip = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Reference: Q is known once S!=R has been applied and equals that S;
    // S=R=0 keeps it, S=R=1 makes it unknown (not compared).
    function automatic exp_t ref_run(input int md, input logic [11:0] mk, input int c0);
        exp_t r;
        bit   known = 0;
        bit   e = 0;
        bit   qo, nqo;
        r.c0 = c0; r.err = 4'd0; r.fs = 4'hF;
        for (int k = 0; k < 12; k++) begin
            if (s_t[k] != r_t[k]) begin known = 1; e = s_t[k]; end
            else if (s_t[k] && r_t[k]) known = 0;
            if (known) begin
                case (md)
                    1:       begin qo = 0; nqo = 1; end
                    2:       begin qo = 1; nqo = 0; end
                    3:       begin qo = e; nqo = e; end
                    default: begin qo = e; nqo = !e; end
                endcase
                if (mk[k]) begin qo = !qo; nqo = !nqo; end
                if (qo != e || nqo == e) begin
                    if (r.err != 4'hF) r.err = r.err + 4'd1;
                    if (r.fs == 4'hF) r.fs = 4'(k);
                end
            end
        end
        r.ps = (r.err == 4'd0);
        return r;
    endfunction

    // Monitor: scoreboard pop on the rising edge of done.
    initial begin
        logic pdone;
        exp_t e;
        pdone = 1'b0;
        forever begin
            @(negedge C);
            if (!done) chk("pass_low_when_not_done", pass, 1'b0);
            if (done && !pdone) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: done rose with no run pending at cycle %0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("latency",   cyc - e.c0, 24);
                    chk("err_cnt",   err_cnt, e.err);
                    chk("fail_step", fail_step, e.fs);
                    chk("pass",      pass, e.ps);
                    chk("busy_off",  busy, 1'b0);
                    chk("sr_idle",   {s_out, r_out}, 2'b00);
                    chk("step_end",  step, 4'd11);
                end
            end
            pdone = done;
        end
    end

    task automatic reset_vals(input string tag);
        chk({tag, "_s"},    s_out, 1'b0);
        chk({tag, "_r"},    r_out, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_pass"}, pass, 1'b0);
        chk({tag, "_err"},  err_cnt, 4'd0);
        chk({tag, "_fs"},   fail_step, 4'hF);
        chk({tag, "_step"}, step, 4'd0);
    endtask

    // Issue a one-cycle start pulse; cur_c0 is the cycle count after the start edge.
    task automatic issue(input int md, input logic [11:0] mk, input bit push);
        @(negedge C);
        mode = md; mask = mk;
        cur_c0 = cyc + 1;
        if (push) sbq.push_back(ref_run(md, mk, cur_c0));
        start = 1'b1;
        @(posedge C);
        #1;
        chk("busy_on", busy, 1'b1);
        chk("step_zero", step, 4'd0);
        @(negedge C);
        start = 1'b0;
    endtask

    // Wait for done with a cycle bound; optionally pulse start mid-run.
    task automatic wait_done(input int pulse_at);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge C);
            if (done) begin seen = 1; break; end
            start = (i == pulse_at);
        end
        start = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: done not seen within 40 cycles at cycle %0d", cyc);
        end
    endtask

    initial begin
        nRST = 1'b0; start = 1'b0;
        #12;
        reset_vals("por");
        @(negedge C); nRST = 1'b1;
        repeat (3) @(negedge C);
        reset_vals("idle_hold");

        issue(0, 12'h000, 1); wait_done(-1);
        issue(1, 12'h000, 1); wait_done(-1);
        issue(2, 12'h000, 1); wait_done(5);
        issue(3, 12'h000, 1); wait_done(-1);

        // Abort in step 5, then a clean run.
        issue(0, 12'h000, 0);
        while (cyc - cur_c0 < 11) @(negedge C);
        nRST = 1'b0;
        #1 reset_vals("abort");
        repeat (2) @(negedge C);
        reset_vals("abort_low");
        nRST = 1'b1;
        repeat (3) @(negedge C);
        reset_vals("abort_idle");
        issue(0, 12'h000, 1); wait_done(-1);

        // start held high through a run: restart on the edge after done.
        @(negedge C);
        mode = 2; mask = '0;
        cur_c0 = cyc + 1;
        sbq.push_back(ref_run(2, 12'h000, cur_c0));
        start = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge C);
                if (done) begin seen = 1; break; end
                if (i > 0) chk("held_busy", busy, 1'b1);
            end
            if (!seen) begin
                total++; bad++;
                $display("FAIL held_timeout: done not seen at cycle %0d", cyc);
            end
        end
        mode = 0; mask = '0;
        cur_c0 = cyc + 1;
        sbq.push_back(ref_run(0, 12'h000, cur_c0));
        @(posedge C);
        #1;
        chk("restart_busy", busy, 1'b1);
        chk("restart_done", done, 1'b0);
        chk("restart_err",  err_cnt, 4'd0);
        chk("restart_fs",   fail_step, 4'hF);
        chk("restart_step", step, 4'd0);
        @(negedge C); start = 1'b0;
        wait_done(-1);

        // Randomised runs: fault mode, inversion mask, idle gap, stray start.
        for (int n = 0; n < 10; n++) begin
            int md;
            logic [11:0] mk;
            md = $urandom_range(0, 3);
            mk = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
            repeat ($urandom_range(0, 3)) @(negedge C);
            issue(md, mk, 1);
            wait_done($urandom_range(0, 19));
        end

        repeat (3) @(negedge C);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound reached");
        $fatal(1);
    end

endmodule

// File: doc/sr_ff_checker.md
SR_FF_CHECKER -- requirements
Module: sr_ff_checker

Interface
REQ-001 The block SHALL have no parameters; the vector table is fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. It SHALL have the ports below.
- C  input  1  clock; all state changes on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE or DONE only.
- q_in  input  1  Q from the flip-flop under test, clocked by the same C.
- nq_in  input  1  nQ from the flip-flop under test.
- s_out  output  1  S drive to the flip-flop under test (registered).
- r_out  output  1  R drive to the flip-flop under test (registered).
- busy  output  1  run in progress.
- done  output  1  run complete; held until restart or reset.
- pass  output  1  done=1 and err_cnt=0.
- err_cnt  output  4  mismatch count, saturating at 15.
- fail_step  output  4  index of the first failing step; 4'hF if none.
- step  output  4  current vector index.

Function
REQ-003 The FSM SHALL have four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-004 Vector table (step: S R, expected Q):
- 0: 0 1, 0
- 1: 0 0, 0
- 2: 1 0, 1
- 3: 0 0, 1
- 4: 0 1, 0
- 5: 1 0, 1
- 6: 1 1, none
- 7: 0 0, none
- 8: 1 0, 1
- 9: 0 0, 1
- 10: 0 1, 0
- 11: 0 0, 0
REQ-005 IDLE or DONE with start=1 at an edge:
- clear err_cnt to 0 and fail_step to 4'hF;
- set step=0, load s_out/r_out from vector 0;
- set busy=1 and done=0; go to DRIVE.
REQ-006 DRIVE SHALL go to SAMPLE on the next edge, holding s_out/r_out.
REQ-007 On the edge leaving SAMPLE, the block SHALL compare q_in and nq_in against the model. This compare point is 2 edges after the vector is applied, which lets the slave's falling-edge transfer settle.
REQ-008 Compare rule, applied only when the model is valid: a mismatch is q_in != expected, or nq_in != ~expected.
REQ-009 Model validity:
- invalid after start;
- valid after any step with S != R;
- invalid after a step with S=R=1;
- S=R=0 leaves validity unchanged.
- Steps 6 and 7 SHALL therefore not be compared, and step 8 re-validates the model.
REQ-010 On a mismatch:
- err_cnt SHALL increment, saturating at 15;
- fail_step SHALL capture the step index only if it is still 4'hF.
REQ-011 After the compare, if step<11 the block SHALL increment step, load the next vector and go to DRIVE; if step=11 it SHALL go to DONE with busy=0 and done=1.
REQ-012 Latency: done SHALL rise on the 24th rising edge after the start edge, with exactly 10 compared steps.
REQ-013 In DONE, s_out and r_out SHALL be 0. step, err_cnt and fail_step SHALL hold.
REQ-014 pass SHALL equal done AND (err_cnt==0), and SHALL be 0 whenever done=0.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 A start held high SHALL NOT restart the run until the FSM reaches DONE. Holding start high in DONE SHALL restart on the next edge.
REQ-017 Inputs q_in and nq_in SHALL NOT be resynchronised, because the DUT shares clock C.

Reset
REQ-018 While nRST=0, the block SHALL immediately force all of the following, regardless of C:
- state=IDLE;
- s_out=0, r_out=0;
- busy=0, done=0, pass=0;
- err_cnt=0, fail_step=4'hF, step=0;
- model invalid.
REQ-019 Reset asserted mid-run SHALL abort the run with no partial result retained. After reset release, no output SHALL change until start=1.

Verification
REQ-020 Correct master-slave SR flip-flop model as DUT, start pulsed for 1 cycle -> busy for 24 cycles, then done=1, pass=1, err_cnt=0, fail_step=F.
REQ-021 q_in stuck at 0 (nq_in stuck at 1) -> failures at steps 2,3,5,8,9; err_cnt=5, fail_step=2, pass=0.
REQ-022 q_in stuck at 1 (nq_in stuck at 0) -> failures at steps 0,1,4,10,11; err_cnt=5, fail_step=0.
REQ-023 Healthy q_in with nq_in tied equal to q_in -> all 10 compared steps fail; err_cnt=10, fail_step=0.
REQ-024 nRST pulsed low during step 5, then start -> outputs at reset values while low; the second run completes cleanly with pass=1, and done rises 24 edges after the new start.
REQ-025 start held high through an entire run -> no restart while busy; restart occurs on the edge after done, err_cnt clears and step=0.
